// File: rtl/univ_shift_reg.sv
// WIDTH-bit universal shift register (hold / shift right / shift left / rotate / load), updated on the falling edge of c.
// One falling edge from inputs to q; the serial outputs are combinational taps of q.
module univ_shift_reg #(
  parameter int WIDTH = 8
) (
  input  logic             c,
  input  logic             re,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic             rot,
  input  logic             sr_in,
  input  logic             sl_in,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] q_,
  output logic             sr_out,
  output logic             sl_out
);

  typedef enum logic [1:0] {
    MODE_HOLD = 2'b00,
    MODE_SHR  = 2'b01,
    MODE_SHL  = 2'b10,
    MODE_LOAD = 2'b11
  } mode_e;

  logic [WIDTH-1:0] shr_val;
  logic [WIDTH-1:0] shl_val;
  logic [WIDTH-1:0] q_next;
  logic             shr_fill;
  logic             shl_fill;

  // End-bit fill: rotation feeds back the bit leaving the opposite end.
  assign shr_fill = rot ? q[0]       : sr_in;
  assign shl_fill = rot ? q[WIDTH-1] : sl_in;

  // Per-bit neighbour selection for both shift directions.
  genvar i;
  generate
    for (i = 0; i < WIDTH; i++) begin : g_bit
      if (i == WIDTH-1) begin : g_top
        assign shr_val[i] = shr_fill;
      end else begin : g_mid_r
        assign shr_val[i] = q[i+1];
      end
      if (i == 0) begin : g_bot
        assign shl_val[i] = shl_fill;
      end else begin : g_mid_l
        assign shl_val[i] = q[i-1];
      end
    end
  endgenerate

  always_comb begin
    q_next = q;
    if (en) begin
      case (mode_e'(mode))
        MODE_SHR:  q_next = shr_val;
        MODE_SHL:  q_next = shl_val;
        MODE_LOAD: q_next = d;
        default:   q_next = q;
      endcase
    end
  end

  always_ff @(negedge c) begin
    if (re) begin
      q <= '0;
    end else begin
      q <= q_next;
    end
  end

  assign q_     = ~q;
  assign sr_out = q[0];
  assign sl_out = q[WIDTH-1];

endmodule
